generador_rebote: RTL and testbench

Bounce emulator: converts a clean logic level (`pulso_ideal`) into a mechanically realistic bouncing signal (`pulso_real`) for hardware-in-the-loop exercising of the debounce filter on the board. Each accepted level change produces a burst of pseudo-random-width glitches that settles to the new level within a bounded window. It sits between the stimulus generator and the debounce filter input.

---
 rtl/generador_rebote_pkg.sv | 24 ++
 rtl/generador_rebote_lfsr16.sv | 27 ++
 rtl/generador_rebote.sv | 132 +++++++++++++
 tb/tb_generador_rebote.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/generador_rebote_pkg.sv
// Shared types and helpers for the bounce emulator: FSM states, LFSR taps and
// a width helper for the internal counters.
package generador_rebote_pkg;

  typedef enum logic [1:0] {
    REPOSO,
    REBOTE,
    ESPERA
  } estado_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Bits needed to index `valor` distinct values; never less than one bit.
  function automatic int clog2(input int valor);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < valor) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/generador_rebote_lfsr16.sv
// 16-bit Galois LFSR that free-runs every cycle; a zero seed is replaced by 1
// so the register can never lock up.
module lfsr16
  import generador_rebote_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] seed_ok;

  assign seed_ok = (seed == 16'd0) ? 16'd1 : seed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= seed_ok;
    end else begin
      state_q <= {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_TAPS : 16'd0);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/generador_rebote.sv
// Bounce emulator: turns a clean level into a burst of glitches that settles on
// the new level. Define GENERADOR_REBOTE_ALEATORIO_EN for LFSR-driven gaps.
module generador_rebote
  import generador_rebote_pkg::*;
#(
  parameter int          FREQ_CLK_HZ   = 50_000_000,
  parameter int          VENTANA_US    = 1000,
  parameter int          N_REBOTES     = 4,
  parameter int          MAX_INTERVALO = 256,
  parameter int          T_ESTABLE     = 1000,
  parameter logic [15:0] SEMILLA       = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulso_ideal,
  input  logic       habilitar,
  output logic       pulso_real,
  output logic       ocupado,
  output logic [7:0] cuenta_flancos
);

  localparam int VENTANA_CICLOS = FREQ_CLK_HZ / 1_000_000 * VENTANA_US;
  localparam int IW = clog2(MAX_INTERVALO + 1);
  localparam int TW = clog2(2 * N_REBOTES + 1);
  localparam int VW = clog2(VENTANA_CICLOS + 1);
  localparam int EW = clog2(T_ESTABLE + 1);

  logic [IW-1:0] intervalo_nuevo;

`ifdef GENERADOR_REBOTE_ALEATORIO_EN
  logic [15:0] lfsr;
  logic [15:0] mascara;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .seed  (SEMILLA),
    .state (lfsr)
  );

  assign mascara         = 16'(MAX_INTERVALO - 1);
  assign intervalo_nuevo = IW'(lfsr & mascara) + IW'(1);
`else
  assign intervalo_nuevo = IW'(MAX_INTERVALO);
`endif

  estado_t       estado_q;
  logic          p_reg_q;
  logic          nivel_q;
  logic          objetivo_q;
  logic          pulso_q;
  logic          ocupado_q;
  logic [7:0]    cuenta_q;
  logic [IW-1:0] intervalo_q;
  logic [TW-1:0] toggles_q;
  logic [VW-1:0] ventana_q;
  logic [EW-1:0] espera_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q    <= REPOSO;
      p_reg_q     <= 1'b0;
      nivel_q     <= 1'b0;
      objetivo_q  <= 1'b0;
      pulso_q     <= 1'b0;
      ocupado_q   <= 1'b0;
      cuenta_q    <= 8'd0;
      intervalo_q <= '0;
      toggles_q   <= '0;
      ventana_q   <= '0;
      espera_q    <= '0;
    end else begin
      p_reg_q <= pulso_ideal;
      case (estado_q)
        REPOSO: begin
          if (p_reg_q != nivel_q) begin
            objetivo_q <= p_reg_q;
            ocupado_q  <= 1'b1;
            ventana_q  <= '0;
            espera_q   <= '0;
            pulso_q    <= ~pulso_q;
            if (habilitar) begin
              toggles_q   <= TW'(2 * N_REBOTES);
              intervalo_q <= intervalo_nuevo;
              estado_q    <= REBOTE;
            end else begin
              pulso_q  <= p_reg_q;
              estado_q <= ESPERA;
            end
          end
        end

        REBOTE: begin
          ventana_q <= ventana_q + VW'(1);
          // The window cap wins over a toggle due on the same cycle.
          if (ventana_q == VW'(VENTANA_CICLOS - 1)) begin
            pulso_q  <= objetivo_q;
            estado_q <= ESPERA;
          end else if (intervalo_q == IW'(1)) begin
            pulso_q     <= ~pulso_q;
            toggles_q   <= toggles_q - TW'(1);
            intervalo_q <= intervalo_nuevo;
            if (toggles_q == TW'(1)) begin
              pulso_q  <= objetivo_q;
              estado_q <= ESPERA;
            end
          end else begin
            intervalo_q <= intervalo_q - IW'(1);
          end
        end

        ESPERA: begin
          if (espera_q == EW'(T_ESTABLE - 1)) begin
            nivel_q   <= objetivo_q;
            ocupado_q <= 1'b0;
            if (cuenta_q != 8'hFF) cuenta_q <= cuenta_q + 8'd1;
            estado_q  <= REPOSO;
          end else begin
            espera_q <= espera_q + EW'(1);
          end
        end

        default: estado_q <= REPOSO;
      endcase
    end
  end

  assign pulso_real     = pulso_q;
  assign ocupado        = ocupado_q;
  assign cuenta_flancos = cuenta_q;

endmodule

// File: tb/tb_generador_rebote.sv
// Bench for generador_rebote: random-habilitar edges checked against timing
// rules (latency, toggle count, gaps, settle time, counter) plus cap/reset cases.
module tb_generador_rebote;

  localparam int N      = 3;
  localparam int MAXI   = 8;
  localparam int T      = 20;
  localparam int VENT   = 100;
  localparam int NCAP   = 10;
  localparam int MAXCAP = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pi = 1'b0, hab = 1'b0, pi_c = 1'b0, hab_c = 1'b0;
  logic       pr, oc, pr_c, oc_c;
  logic [7:0] cf, cf_c;

  always #5 clk = ~clk;

  generador_rebote #(
    .FREQ_CLK_HZ(50_000_000), .VENTANA_US(2), .N_REBOTES(N),
    .MAX_INTERVALO(MAXI), .T_ESTABLE(T), .SEMILLA(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .pulso_ideal(pi), .habilitar(hab),
    .pulso_real(pr), .ocupado(oc), .cuenta_flancos(cf)
  );

  generador_rebote #(
    .FREQ_CLK_HZ(50_000_000), .VENTANA_US(2), .N_REBOTES(NCAP),
    .MAX_INTERVALO(MAXCAP), .T_ESTABLE(T), .SEMILLA(16'hACE1)
  ) dut_cap (
    .clk(clk), .rst(rst), .pulso_ideal(pi_c), .habilitar(hab_c),
    .pulso_real(pr_c), .ocupado(oc_c), .cuenta_flancos(cf_c)
  );

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   failures = 0;
  int   model_cnt = 0;
  int   tq[$];
  int   tqc[$];
  logic pr_last = 1'b0;
  logic prc_last = 1'b0;
  logic cur = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and log output transitions with their cycle.
  task automatic step();
    @(negedge clk);
    if (pr !== pr_last) begin
      tq.push_back(cyc);
      pr_last = pr;
    end
    if (pr_c !== prc_last) begin
      tqc.push_back(cyc);
      prc_last = pr_c;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_edge(input logic lvl, input logic h, input bit glitch);
    int   c0, rise, fall, n, glen, gap;
    logic oc_last;
    tq.delete();
    c0 = cyc; pi = lvl; hab = h;
    rise = -1; fall = -1; oc_last = oc;
    glen = $urandom_range(1, 8);
    for (int k = 0; k < 400 && fall < 0; k++) begin
      step();
      if (cyc - c0 == 2) hab = 1'($urandom_range(0, 1));
      if (glitch && cyc - c0 == 5) pi = ~lvl;
      if (glitch && cyc - c0 == 5 + glen) pi = lvl;
      if (oc && !oc_last) rise = cyc;
      if (!oc && oc_last) fall = cyc;
      oc_last = oc;
    end
    check("busy_timeout", 32'(fall >= 0), 32'd1);
    model_cnt = (model_cnt == 255) ? 255 : model_cnt + 1;
    n = tq.size();
    check("toggle_count", 32'(n), h ? 32'(2 * N + 1) : 32'd1);
    if (n > 0) begin
      check("first_toggle_latency", 32'(tq[0] - c0), 32'd2);
      check("ocupado_rise_latency", 32'(rise - c0), 32'd2);
      for (int i = 1; i < n; i++) begin
        gap = tq[i] - tq[i-1];
`ifdef GENERADOR_REBOTE_ALEATORIO_EN
        check("gap_in_range", 32'(gap >= 1 && gap <= MAXI), 32'd1);
`else
        check("gap_fixed", 32'(gap), 32'(MAXI));
`endif
      end
      check("burst_in_window", 32'(tq[n-1] - tq[0] <= VENT), 32'd1);
      check("settle_time", 32'(fall - tq[n-1]), 32'(T));
    end
    check("final_level", 32'(pr), 32'(lvl));
    check("edge_count", 32'(cf), 32'(model_cnt));
    $display("edge lvl=%0d hab=%0d glitch=%0d toggles=%0d count=%0d",
             lvl, h, glitch, n, cf);
    cur = lvl;
  endtask

  initial begin
    int   c0, fall;
    logic oc_last;
    bit   stays;

    // Reset with pulso_ideal low.
    step(); step();
    check("rst_pulso_real", 32'(pr), 32'd0);
    check("rst_ocupado", 32'(oc), 32'd0);
    check("rst_cuenta", 32'(cf), 32'd0);
    check("rst_cap_pulso_real", 32'(pr_c), 32'd0);
    check("rst_cap_cuenta", 32'(cf_c), 32'd0);
    rst = 1'b0;
    $display("reset done");

    // Window cap: 10 bounces of up to 64 cycles cannot fit in 100 cycles.
    tqc.delete();
    c0 = cyc; pi_c = 1'b1; hab_c = 1'b1;
    fall = -1; oc_last = oc_c; stays = 1'b1;
    for (int k = 0; k < 400 && fall < 0; k++) begin
      step();
      if (cyc - c0 >= 2 + VENT && pr_c !== 1'b1) stays = 1'b0;
      if (!oc_c && oc_last) fall = cyc;
      oc_last = oc_c;
    end
    check("cap_timeout", 32'(fall >= 0), 32'd1);
    check("cap_level_held", 32'(stays), 32'd1);
    check("cap_last_toggle", 32'(tqc.size() > 0 && tqc[tqc.size()-1] - c0 <= 2 + VENT), 32'd1);
    check("cap_final_level", 32'(pr_c), 32'd1);
    check("cap_count", 32'(cf_c), 32'd1);
`ifdef GENERADOR_REBOTE_ALEATORIO_EN
    check("cap_fall_bound", 32'(fall - c0 <= 2 + VENT + T), 32'd1);
`else
    check("cap_toggles", 32'(tqc.size()), 32'd3);
    if (tqc.size() == 3) begin
      check("cap_second_toggle", 32'(tqc[1] - c0), 32'(2 + MAXCAP));
      check("cap_forced_toggle", 32'(tqc[2] - c0), 32'(2 + VENT));
    end
    check("cap_fall", 32'(fall - c0), 32'(2 + VENT + T));
`endif
    $display("window cap toggles=%0d count=%0d", tqc.size(), cf_c);

    // Directed rising bounce and clean falling edge, then random edges.
    do_edge(1'b1, 1'b1, 1'b0);
    do_edge(1'b0, 1'b0, 1'b0);
    for (int e = 0; e < 5; e++) begin
      idle($urandom_range(0, 4));
      do_edge(~cur, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Glitch on the input while settling must be ignored.
    do_edge(~cur, 1'b0, 1'b1);
    tq.delete();
    idle(30);
    check("glitch_no_toggles", 32'(tq.size()), 32'd0);
    check("glitch_count", 32'(cf), 32'(model_cnt));
    check("glitch_idle", 32'(oc), 32'd0);
    $display("glitch window toggles=%0d count=%0d", tq.size(), cf);

    // Reset in the middle of a burst, then a fresh burst from 0.
    if (cur == 1'b1) do_edge(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    c0 = cyc; pi = 1'b1; hab = 1'b1;
    while (cyc - c0 < 4) step();
    rst = 1'b1;
    step();
    check("midrst_pulso_real", 32'(pr), 32'd0);
    check("midrst_ocupado", 32'(oc), 32'd0);
    check("midrst_cuenta", 32'(cf), 32'd0);
    model_cnt = 0;
    rst = 1'b0;
    $display("mid-burst reset pulso_real=%0d", pr);
    do_edge(1'b1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
